i2c_slave: RTL



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block: FSM state encoding
// and bus-level widths/levels.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the pad-level SCL/SDA into the clk domain and derives SCL edges
// plus START/STOP pulses from the synchronized and history samples.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_rise;
  logic                   sda_fall;

  // Flops reset to 1 so an idle (pulled-up) bus produces no edges on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign sda_rise = sda_s & ~sda_hist_q;
  assign sda_fall = ~sda_s & sda_hist_q;
  assign start    = sda_fall & scl_s;
  assign stop     = sda_rise & scl_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: decodes address/data on the oversampled bus and exchanges
// bytes with local logic; SDA is only ever pulled low, never driven high.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'b1110000,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  busy,
  output logic                  addressed
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e            state_q, state_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;
  logic                  addressed_q, addressed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    unique case (state_q)
      ADDR: if (scl_rise) begin
        shift_d  = {shift_q[I2C_BYTE_W-2:0], sda_s};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd7) begin
          bitcnt_d = '0;
          if (shift_q[I2C_ADDR_W-1:0] == SLAVE_ADDR) begin
            rw_d        = sda_s;
            addressed_d = 1'b1;
            state_d     = ADDR_ACK;
          end else begin
            state_d = WAIT_STOP;
          end
        end
      end
      // sda_oe doubles as the phase flag: low = ACK not yet driven.
      ADDR_ACK: begin
        if (scl_rise && rw_q) tx_req_d = 1'b1;
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[I2C_BYTE_W-1];
            state_d  = READ;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
      end
      WRITE: if (scl_rise) begin
        shift_d  = {shift_q[I2C_BYTE_W-2:0], sda_s};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd7) begin
          bitcnt_d   = '0;
          rx_data_d  = {shift_q[I2C_BYTE_W-2:0], sda_s};
          rx_valid_d = 1'b1;
          state_d    = WRITE_ACK;
        end
      end
      WRITE_ACK: if (scl_fall) begin
        if (!sda_oe_q) begin
          sda_oe_d = 1'b1;
        end else begin
          sda_oe_d = 1'b0;
          state_d  = WRITE;
        end
      end
      // bitcnt counts bits the master has sampled; the MSB is already on the bus.
      READ: begin
        if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
        if (scl_fall) begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            state_d  = READ_ACK;
          end else if (bitcnt_q != 4'd0) begin
            shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[I2C_BYTE_W-2];
          end
        end
      end
      READ_ACK: begin
        if (scl_rise) begin
          if (sda_s == I2C_ACK) begin
            tx_req_d = 1'b1;
            bitcnt_d = 4'd1;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        if (scl_fall && bitcnt_q == 4'd1) begin
          bitcnt_d = '0;
          shift_d  = tx_data;
          sda_oe_d = ~tx_data[I2C_BYTE_W-1];
          state_d  = READ;
        end
      end
      default: ;
    endcase

    // Bus conditions win over whatever the byte logic decided this cycle.
    if (start) begin
      state_d     = ADDR;
      bitcnt_d    = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
    end else if (stop) begin
      state_d     = IDLE;
      bitcnt_d    = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule
